// File: rtl/add_sub_arbiter.sv
// add_sub_arbiter: round-robin front end for one shared signed CLA adder/subtractor.
// Grants one requester at a time, latches its operands, computes in one cycle
// and holds the registered response until the consumer takes it.
module add_sub_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_result,
  output logic                          rsp_overflow,
  output logic                          busy
);

  localparam int NSLICE = DATA_WIDTH / 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t                state_q, state_d;
  logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic                  op_q, op_d;
  logic [ID_W-1:0]       id_q, id_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]       rsp_id_q, rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic                  rsp_ovf_q, rsp_ovf_d;

  // Unpacked views of the operand buses so only the granted slice is ever selected
  logic [DATA_WIDTH-1:0] req_a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] req_b_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_a_arr[gi] = req_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_b_arr[gi] = req_b[gi*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  // Round-robin search: first valid requester after the last one granted
  logic            grant_found;
  logic [ID_W-1:0] grant_id;
  logic [ID_W-1:0] idx;
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx         = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = ID_W'((int'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_id    = idx;
      end
    end
  end

  // One-hot ready, only while idle and out of reset
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = (state_q == IDLE) & ~rst & grant_found & (grant_id == ID_W'(gi));
    end
  endgenerate

  // Shared datapath: subtraction is a + ~b + 1, built from 4-bit look-ahead slices
  logic [DATA_WIDTH-1:0] beff, p, g, c, sum;
  logic [NSLICE:0]       sc;
  logic                  ovf;

  assign beff  = op_q ? ~b_q : b_q;
  assign p     = a_q ^ beff;
  assign g     = a_q & beff;
  assign sc[0] = op_q;

  generate
    for (gi = 0; gi < NSLICE; gi++) begin : g_cla
      logic [3:0] pp, gg, cc;
      assign pp    = p[gi*4 +: 4];
      assign gg    = g[gi*4 +: 4];
      assign cc[0] = sc[gi];
      assign cc[1] = gg[0] | (pp[0] & cc[0]);
      assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
      assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & cc[0]);
      assign sc[gi+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                      | (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & cc[0]);
      assign c[gi*4 +: 4] = cc;
    end
  endgenerate

  assign sum = p ^ c;
  // Carry into the MSB differing from carry out is the same condition as
  // "operands agree in sign but the sum does not".
  assign ovf = c[DATA_WIDTH-1] ^ sc[NSLICE];

  // Next-state and register-update logic for the IDLE/CALC/RESP sequence
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d      = req_a_arr[grant_id];
          b_d      = req_b_arr[grant_id];
          op_d     = req_op[grant_id];
          id_d     = grant_id;
          rr_ptr_d = grant_id;
          state_d  = CALC;
        end
      end
      CALC: begin
        rsp_result_d = sum;
        rsp_ovf_d    = ovf;
        rsp_id_d     = id_q;
        rsp_valid_d  = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= ID_W'(NUM_REQ - 1);
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
    end
  end

  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_overflow = rsp_ovf_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_add_sub_arbiter.sv
// Testbench for add_sub_arbiter: directed vectors plus randomized traffic
// checked against a plain-arithmetic reference model.
module tb_add_sub_arbiter;

  localparam int DW = 16;
  localparam int NR = 4;
  localparam int IW = 2;

  logic               clk;
  logic               rst;
  logic [NR-1:0]      req_valid;
  logic [NR-1:0]      req_ready;
  logic [NR-1:0]      req_op;
  logic [NR*DW-1:0]   req_a;
  logic [NR*DW-1:0]   req_b;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [DW-1:0]      rsp_result;
  logic               rsp_overflow;
  logic               busy;

  add_sub_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_id       (rsp_id),
    .rsp_result   (rsp_result),
    .rsp_overflow (rsp_overflow),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] a_v  [NR];
  logic [DW-1:0] b_v  [NR];
  logic          op_v [NR];
  int            last_g;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first set bit after the previously granted requester
  function automatic int model_grant(input logic [NR-1:0] mask);
    for (int i = 1; i <= NR; i++) begin
      int k;
      k = (last_g + i) % NR;
      if (mask[k]) return k;
    end
    return -1;
  endfunction

  task automatic rand_ops();
    for (int k = 0; k < NR; k++) begin
      a_v[k]  = DW'($urandom);
      b_v[k]  = DW'($urandom);
      op_v[k] = 1'($urandom);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < NR; k++) begin
      req_a[k*DW +: DW] = a_v[k];
      req_b[k*DW +: DW] = b_v[k];
      req_op[k]         = op_v[k];
    end
  endtask

  // One full transaction, starting 1 time unit after a rising edge in IDLE
  task automatic run_txn(input logic [NR-1:0] mask, input int hold);
    int            g, sa, sb, r;
    logic [DW-1:0] er, held;
    logic          eo;
    g = model_grant(mask);
    drive_ops();
    req_valid = mask;
    #4;
    check_val("grant_ready", 32'(req_ready), 32'(1 << g));
    check_val("busy_idle", 32'(busy), 32'd0);
    sa = $signed(a_v[g]);
    sb = $signed(b_v[g]);
    r  = op_v[g] ? (sa - sb) : (sa + sb);
    er = r[DW-1:0];
    eo = (r > 32767) || (r < -32768);
    last_g = g;
    @(posedge clk); #1;
    req_valid = mask & ~(NR'(1) << g);
    check_val("calc_busy", 32'(busy), 32'd1);
    check_val("calc_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("calc_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    check_val("rsp_valid", 32'(rsp_valid), 32'd1);
    check_val("rsp_id", 32'(rsp_id), 32'(g));
    check_val("rsp_result", 32'(rsp_result), 32'(er));
    check_val("rsp_overflow", 32'(rsp_overflow), 32'(eo));
    check_val("resp_ready", 32'(req_ready), 32'd0);
    held = rsp_result;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check_val("hold_valid", 32'(rsp_valid), 32'd1);
      check_val("hold_result", 32'(rsp_result), 32'(held));
      check_val("hold_id", 32'(rsp_id), 32'(g));
      check_val("hold_busy", 32'(busy), 32'd1);
      check_val("hold_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_val("done_valid", 32'(rsp_valid), 32'd0);
    check_val("done_busy", 32'(busy), 32'd0);
    req_valid = '0;
    $display("txn mask=%b grant=%0d op=%0d a=%h b=%h result=%h ovf=%0d hold=%0d",
             mask, g, op_v[g], a_v[g], b_v[g], er, eo, hold);
  endtask

  logic [DW-1:0] dv_a  [5];
  logic [DW-1:0] dv_b  [5];
  logic          dv_op [5];

  initial begin
    dv_a[0] = 16'h0005; dv_b[0] = 16'h0003; dv_op[0] = 1'b0;
    dv_a[1] = 16'h0003; dv_b[1] = 16'h0005; dv_op[1] = 1'b1;
    dv_a[2] = 16'h7FFF; dv_b[2] = 16'hFFFF; dv_op[2] = 1'b1;
    dv_a[3] = 16'h0000; dv_b[3] = 16'h8000; dv_op[3] = 1'b1;
    dv_a[4] = 16'h8000; dv_b[4] = 16'h0001; dv_op[4] = 1'b1;

    // Reset with arbitrary inputs: every output must stay zero
    rst       = 1'b1;
    rsp_ready = 1'b0;
    rand_ops();
    drive_ops();
    req_valid = NR'($urandom_range(1, 15));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("rst_rsp_id", 32'(rsp_id), 32'd0);
      check_val("rst_rsp_result", 32'(rsp_result), 32'd0);
      check_val("rst_rsp_ovf", 32'(rsp_overflow), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_ready", 32'(req_ready), 32'd0);
      req_valid = NR'($urandom_range(1, 15));
    end
    req_valid = '0;
    rst       = 1'b0;
    last_g    = NR - 1;
    @(posedge clk); #1;

    // All requesters valid: rotation 0,1,2,3,0 carrying the directed vectors
    for (int t = 0; t < 5; t++) begin
      rand_ops();
      for (int k = 0; k < NR; k++) begin
        a_v[k] = dv_a[t]; b_v[k] = dv_b[t]; op_v[k] = dv_op[t];
      end
      run_txn(4'b1111, 0);
    end

    // Only requesters 1 and 3: alternate, with backpressure on one response
    for (int t = 0; t < 4; t++) begin
      rand_ops();
      run_txn(4'b1010, (t == 2) ? 5 : 0);
    end

    // Reset while requester 2 is being computed: response must never appear
    rand_ops();
    drive_ops();
    req_valid = 4'b0100;
    #4;
    check_val("midrst_grant", 32'(req_ready), 32'(1 << model_grant(4'b0100)));
    @(posedge clk); #1;
    check_val("midrst_calc", 32'(busy), 32'd1);
    rst       = 1'b1;
    req_valid = '0;
    #1;
    check_val("midrst_busy", 32'(busy), 32'd0);
    check_val("midrst_valid", 32'(rsp_valid), 32'd0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check_val("midrst_novalid", 32'(rsp_valid), 32'd0);
    end
    rst    = 1'b0;
    last_g = NR - 1;
    @(posedge clk); #1;
    check_val("postrst_novalid", 32'(rsp_valid), 32'd0);
    rand_ops();
    run_txn(4'b0101, 0);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      rand_ops();
      run_txn(NR'($urandom_range(1, 15)), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
